crcu_clk_div_ctl: RTL and testbench
===================================

Name: crcu_clk_div_ctl

Overview:
- Multi-channel, register-controlled clock generator inside the CRCU.
- Each channel derives a divided clock from CRCU_CLK, selected by a 32-bit control word written over APB by the register file.
- Supports glitch-free divisor change, clean gating and enable at period boundaries, and per-channel status.
- Replaces the per-peripheral single-divider clock control blocks.

Parameters:
- NUM_CH, 4: number of independent clock channels.
- CNT_W, 8: divider counter width; maximum divisor is 2^CNT_W - 1.
- RST_SEL, 3'd0: divisor select loaded into the active configuration at reset.

Ports:
- CRCU_CLK  input  1  source clock; single clock domain.
- CRCU_RST_N  input  1  asynchronous, active-low reset.
- clk_ctl_reg  input  NUM_CH*32  per-channel control word; channel i occupies [32*i+31:32*i].
- clk_out  output  NUM_CH  registered divided clocks.
- clk_active  output  NUM_CH  1 while the channel is toggling.
- cfg_ack  output  NUM_CH  1-cycle pulse when a new divisor takes effect.
- cfg_err  output  NUM_CH  sticky flag for a reserved select; cleared only by reset.

Behaviour:
- Control word fields: [2:0] sel, [3] en, [4] gate (1 = gate off), [5] direct, [15:8] div. Fields [5] and [15:8] exist only with the optional feature. Other bits are ignored.
- Divisor table, indexed by sel 0..6: 2, 3, 4, 6, 8, 12, 16. sel=7 is reserved.
- Reset values: clk_out=0, clk_active=0, cfg_ack=0, cfg_err=0. All channels are IDLE with counter 0 and active divisor = table[RST_SEL].
- Input sampling: clk_ctl_reg is registered once (stage S). All decisions use S, so the output reacts 2 edges after a control change.
- Run condition: run = en & ~gate.
- Divider with active divisor N:
  - counter counts 0..N-1 and wraps.
  - clk_out is high while cnt < N/2 (floor), low otherwise.
  - Even N gives 50% duty; odd N is high floor(N/2), low ceil(N/2) cycles.
  - N < 2 is forced to 2.
- Per-channel FSM states: IDLE, RUN, PEND, STOP.
- IDLE:
  - clk_out=0, cnt=0, clk_active=0.
  - When run=1 go to RUN, with cnt=0 and clk_out=1 on the same edge.
  - A new divisor requested while in IDLE is loaded immediately with no ack.
- RUN:
  - clk_active=1.
  - If the requested divisor != active divisor, capture it as pending and go to PEND.
  - If run=0, go to STOP.
- PEND:
  - The current period completes unchanged.
  - At cnt==N-1 (clk_out low): load the pending divisor, set cnt=0 and clk_out=1 on the next edge, pulse cfg_ack for 1 cycle, return to RUN.
  - If the request changes again while in PEND, the latest value overwrites pending. Only one ack is issued.
- STOP:
  - The current period completes.
  - At cnt==N-1, go to IDLE with clk_out=0.
  - If run returns to 1 before then, go back to RUN with no truncated pulse.
  - A pending divisor is applied on entry to IDLE, with no ack.
- Simultaneous divisor change and run=0 in RUN: STOP wins and the divisor is loaded on entering IDLE.
- Reserved sel=7 (or direct div<2 with the feature): the request is ignored, the active divisor is retained, and cfg_err is set.
- Guarantees: no high or low phase on clk_out is ever shorter than floor(N_min/2) cycles of CRCU_CLK, where N_min is the smaller of the old and new divisors.
- Reset mid-operation: asynchronous return to reset values; clk_out drops immediately.

Optional Feature:
- CRCU_CLK_DIRECT_DIV_EN defined: when bit[5]=1, the divisor is taken from [15:8] instead of the table. div of 0 or 1 is reserved and sets cfg_err.
- Not defined: bits [5] and [15:8] are ignored and only the table is used.

Decomposition:
- Package crcu_clk_pkg holds:
  - the divisor table constant and field bit-position constants (SEL_LSB, EN_BIT, GATE_BIT, DIRECT_BIT, DIV_LSB);
  - the state enum typedef (IDLE, RUN, PEND, STOP).
- Sub-module crcu_clk_div_ch implements one channel: counter, FSM and status.
- The top instantiates NUM_CH copies with a generate loop and holds the input sampling stage.

Test Plan:
- Reset, then ch0 word 0x08 (sel0, en) -> clk_out[0] rises 2 edges later, period 2 (1 high / 1 low), clk_active[0]=1.
- ch1 running sel2 (N=4), then switch to sel1 (N=3) mid-period -> the current 2H/2L period completes, cfg_ack[1] pulses once, then a 1H/2L pattern with no runt pulse.
- ch2 running N=8, set gate=1 at cnt=2 -> high phase completes (4 cycles), low completes (4 cycles), then IDLE with clk_out=0 and clk_active=0; clear gate -> restart with cnt=0.
- ch3 writes sel=7 while running N=6 -> N stays 6, cfg_err[3]=1 and sticky, no cfg_ack.
- Assert CRCU_RST_N low while clk_out=1 -> all outputs 0 immediately; after release, channels run from table[RST_SEL] when en=1.
- With CRCU_CLK_DIRECT_DIV_EN: word 0x0000_0A28 (direct, en, div=10) -> 5H/5L period; div=1 -> cfg_err set and divisor unchanged.

Source files
------------

// File: rtl/crcu_clk_pkg.sv
// Shared definitions for the CRCU clock divider control block:
// control word field positions, divisor table and channel state enum.
package crcu_clk_pkg;

    localparam int SEL_LSB    = 0;
    localparam int EN_BIT     = 3;
    localparam int GATE_BIT   = 4;
    localparam int DIRECT_BIT = 5;
    localparam int DIV_LSB    = 8;

    localparam logic [2:0] SEL_RSVD = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PEND,
        STOP
    } ch_state_t;

    // Reserved select maps to 2 only so the function is total;
    // callers reject SEL_RSVD before using the value.
    function automatic logic [7:0] div_tbl(input logic [2:0] sel);
        logic [7:0] n;
        case (sel)
            3'd0:    n = 8'd2;
            3'd1:    n = 8'd3;
            3'd2:    n = 8'd4;
            3'd3:    n = 8'd6;
            3'd4:    n = 8'd8;
            3'd5:    n = 8'd12;
            3'd6:    n = 8'd16;
            default: n = 8'd2;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/crcu_clk_div_ch.sv
// One clock channel: divider counter, IDLE/RUN/PEND/STOP FSM and status.
// Ports: clk, rst_n, ctl (sampled control word), clk_out, clk_active,
// cfg_ack (divisor-change pulse), cfg_err (sticky reserved-request flag).
// Build option CRCU_CLK_DIRECT_DIV_EN: divisor from ctl[15:8] when ctl[5]=1.
module crcu_clk_div_ch
    import crcu_clk_pkg::*;
#(
    parameter int         CNT_W   = 8,
    parameter logic [2:0] RST_SEL = 3'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ctl,
    output logic        clk_out,
    output logic        clk_active,
    output logic        cfg_ack,
    output logic        cfg_err
);

    typedef logic [CNT_W-1:0] cnt_t;

    function automatic cnt_t eff_n(input cnt_t n);
        return (n < cnt_t'(2)) ? cnt_t'(2) : n;
    endfunction

    localparam cnt_t RST_N = eff_n(cnt_t'(div_tbl(RST_SEL)));

    ch_state_t st, st_nxt;
    cnt_t      cnt, cnt_nxt;
    cnt_t      n_act, n_act_nxt;
    cnt_t      n_pend, n_pend_nxt;
    logic      pend_vld, pend_nxt;
    logic      ack_nxt, err_nxt, out_nxt;
    logic      run, req_ok, wrap;
    cnt_t      req_n;
    logic      unused_bits;

    assign unused_bits = ^{ctl[31:16], ctl[DIV_LSB +: 8],
                           ctl[DIRECT_BIT], ctl[7:6]};

    always_comb begin
        run    = ctl[EN_BIT] & ~ctl[GATE_BIT];
        req_n  = cnt_t'(div_tbl(ctl[SEL_LSB +: 3]));
        req_ok = ctl[SEL_LSB +: 3] != SEL_RSVD;
`ifdef CRCU_CLK_DIRECT_DIV_EN
        if (ctl[DIRECT_BIT]) begin
            req_n  = cnt_t'(ctl[DIV_LSB +: 8]);
            req_ok = ctl[DIV_LSB +: 8] >= 8'd2;
        end
`endif
    end

    assign wrap = cnt == (eff_n(n_act) - cnt_t'(1));

    always_comb begin
        st_nxt     = st;
        n_act_nxt  = n_act;
        n_pend_nxt = n_pend;
        pend_nxt   = pend_vld;
        cnt_nxt    = wrap ? '0 : cnt + cnt_t'(1);
        ack_nxt    = 1'b0;
        err_nxt    = cfg_err | ~req_ok;
        unique case (st)
            IDLE: begin
                cnt_nxt  = '0;
                pend_nxt = 1'b0;
                if (req_ok) n_act_nxt = req_n;
                if (run) st_nxt = RUN;
            end
            RUN: begin
                if (!run) begin
                    st_nxt = STOP;
                    if (req_ok && req_n != n_act) begin
                        n_pend_nxt = req_n;
                        pend_nxt   = 1'b1;
                    end
                end else if (req_ok && req_n != n_act) begin
                    n_pend_nxt = req_n;
                    st_nxt     = PEND;
                end
            end
            PEND: begin
                // Latest valid request overwrites the pending one.
                if (req_ok) n_pend_nxt = req_n;
                if (!run) begin
                    st_nxt   = STOP;
                    pend_nxt = n_pend_nxt != n_act;
                end else if (wrap) begin
                    n_act_nxt = n_pend_nxt;
                    ack_nxt   = n_pend_nxt != n_act;
                    st_nxt    = RUN;
                end
            end
            STOP: begin
                if (req_ok) begin
                    n_pend_nxt = req_n;
                    pend_nxt   = req_n != n_act;
                end
                if (run) begin
                    // RUN re-checks the request on its next cycle.
                    st_nxt   = RUN;
                    pend_nxt = 1'b0;
                end else if (wrap) begin
                    st_nxt  = IDLE;
                    cnt_nxt = '0;
                    if (pend_nxt) n_act_nxt = n_pend_nxt;
                end
            end
            default: st_nxt = IDLE;
        endcase
    end

    // High for the first floor(N/2) counts of each period.
    assign out_nxt = (st_nxt != IDLE) &&
                     (cnt_nxt < (eff_n(n_act_nxt) >> 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= IDLE;
            cnt      <= '0;
            n_act    <= RST_N;
            n_pend   <= RST_N;
            pend_vld <= 1'b0;
            clk_out  <= 1'b0;
            cfg_ack  <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            st       <= st_nxt;
            cnt      <= cnt_nxt;
            n_act    <= n_act_nxt;
            n_pend   <= n_pend_nxt;
            pend_vld <= pend_nxt;
            clk_out  <= out_nxt;
            cfg_ack  <= ack_nxt;
            cfg_err  <= err_nxt;
        end
    end

    assign clk_active = st != IDLE;

endmodule

// File: rtl/crcu_clk_div_ctl.sv
// CRCU multi-channel clock divider: samples the control words once and
// drives NUM_CH divider channels. Ports: CRCU_CLK, CRCU_RST_N,
// clk_ctl_reg (32 bits per channel), clk_out, clk_active, cfg_ack, cfg_err.
// Build option CRCU_CLK_DIRECT_DIV_EN enables direct divisor selection.
module crcu_clk_div_ctl
    import crcu_clk_pkg::*;
#(
    parameter int         NUM_CH  = 4,
    parameter int         CNT_W   = 8,
    parameter logic [2:0] RST_SEL = 3'd0
) (
    input  logic                CRCU_CLK,
    input  logic                CRCU_RST_N,
    input  logic [NUM_CH*32-1:0] clk_ctl_reg,
    output logic [NUM_CH-1:0]   clk_out,
    output logic [NUM_CH-1:0]   clk_active,
    output logic [NUM_CH-1:0]   cfg_ack,
    output logic [NUM_CH-1:0]   cfg_err
);

    logic [NUM_CH*32-1:0] ctl_s;

    always_ff @(posedge CRCU_CLK or negedge CRCU_RST_N) begin
        if (!CRCU_RST_N) ctl_s <= '0;
        else             ctl_s <= clk_ctl_reg;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        crcu_clk_div_ch #(
            .CNT_W   (CNT_W),
            .RST_SEL (RST_SEL)
        ) u_ch (
            .clk        (CRCU_CLK),
            .rst_n      (CRCU_RST_N),
            .ctl        (ctl_s[32*i +: 32]),
            .clk_out    (clk_out[i]),
            .clk_active (clk_active[i]),
            .cfg_ack    (cfg_ack[i]),
            .cfg_err    (cfg_err[i])
        );
    end

endmodule

// File: tb/tb_crcu_clk_div_ctl.sv
// Directed bench for crcu_clk_div_ctl: start-up, divisor change,
// gating, reserved select, async reset and (optional) direct divisor.
module tb_crcu_clk_div_ctl;

    logic         clk;
    logic         rst_n;
    logic [127:0] ctl;
    logic [3:0]   clk_out;
    logic [3:0]   clk_active;
    logic [3:0]   cfg_ack;
    logic [3:0]   cfg_err;

    int n_vec;
    int n_err;

    crcu_clk_div_ctl dut (
        .CRCU_CLK    (clk),
        .CRCU_RST_N  (rst_n),
        .clk_ctl_reg (ctl),
        .clk_out     (clk_out),
        .clk_active  (clk_active),
        .cfg_ack     (cfg_ack),
        .cfg_err     (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int ch, input logic [31:0] w);
        ctl[32*ch +: 32] = w;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ctl   = '0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({clk_out, clk_active, cfg_ack, cfg_err} !== 16'h0) begin
            n_err++;
            $display("FAIL reset_state got %h want 0000",
                     {clk_out, clk_active, cfg_ack, cfg_err});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_start_ch0();
        logic exp [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        set_word(0, 32'h08);
        for (int k = 0; k < 5; k++) begin
            tick();
            n_vec++;
            if (clk_out[0] !== exp[k]) begin
                n_err++;
                $display("FAIL start_ch0 edge%0d got %b want %b",
                         k + 1, clk_out[0], exp[k]);
            end
        end
        n_vec++;
        if (clk_active[0] !== 1'b1) begin
            n_err++;
            $display("FAIL start_ch0_active got %b want 1", clk_active[0]);
        end
    endtask

    task automatic test_div_change();
        logic eo [8] = '{0, 0, 1, 0, 0, 1, 0, 0};
        logic ea [8] = '{0, 0, 1, 0, 0, 0, 0, 0};
        set_word(1, 32'h0A);
        tick();
        tick();
        tick();
        n_vec++;
        if (clk_out[1] !== 1'b1) begin
            n_err++;
            $display("FAIL chg_pre got %b want 1", clk_out[1]);
        end
        set_word(1, 32'h09);
        for (int k = 0; k < 8; k++) begin
            tick();
            n_vec++;
            if (clk_out[1] !== eo[k] || cfg_ack[1] !== ea[k]) begin
                n_err++;
                $display("FAIL chg_n4_n3 edge%0d got out=%b ack=%b want out=%b ack=%b",
                         k + 1, clk_out[1], cfg_ack[1], eo[k], ea[k]);
            end
        end
    endtask

    task automatic test_gate();
        logic eo [8] = '{1, 1, 1, 0, 0, 0, 0, 0};
        set_word(2, 32'h0C);
        tick();
        tick();
        set_word(2, 32'h1C);
        for (int k = 0; k < 8; k++) begin
            tick();
            n_vec++;
            if (clk_out[2] !== eo[k]) begin
                n_err++;
                $display("FAIL gate_out edge%0d got %b want %b",
                         k + 1, clk_out[2], eo[k]);
            end
            if (k == 6) begin
                n_vec++;
                if (clk_active[2] !== 1'b1) begin
                    n_err++;
                    $display("FAIL gate_active_stop got %b want 1",
                             clk_active[2]);
                end
            end
        end
        tick();
        n_vec++;
        if (clk_active[2] !== 1'b0 || clk_out[2] !== 1'b0) begin
            n_err++;
            $display("FAIL gate_idle got act=%b out=%b want 0 0",
                     clk_active[2], clk_out[2]);
        end
        set_word(2, 32'h0C);
        tick();
        tick();
        n_vec++;
        if (clk_out[2] !== 1'b1 || clk_active[2] !== 1'b1) begin
            n_err++;
            $display("FAIL gate_restart got out=%b act=%b want 1 1",
                     clk_out[2], clk_active[2]);
        end
    endtask

    task automatic test_reserved();
        int acks;
        acks = 0;
        set_word(3, 32'h0B);
        tick();
        tick();
        set_word(3, 32'h0F);
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (cfg_ack[3]) acks++;
            n_vec++;
            if (clk_out[3] !== ((k % 6) < 3)) begin
                n_err++;
                $display("FAIL rsvd_n6 edge%0d got %b want %b",
                         k, clk_out[3], ((k % 6) < 3));
            end
        end
        n_vec++;
        if (cfg_err[3] !== 1'b1) begin
            n_err++;
            $display("FAIL rsvd_err got %b want 1", cfg_err[3]);
        end
        set_word(3, 32'h0B);
        repeat (4) begin
            tick();
            if (cfg_ack[3]) acks++;
        end
        n_vec++;
        if (cfg_err[3] !== 1'b1 || acks != 0) begin
            n_err++;
            $display("FAIL rsvd_sticky got err=%b acks=%0d want 1 0",
                     cfg_err[3], acks);
        end
    endtask

    task automatic test_async_reset();
        logic e0 [4] = '{1, 0, 1, 0};
        logic e1 [4] = '{1, 0, 0, 1};
        set_word(0, 32'h0);
        repeat (6) tick();
        set_word(0, 32'h08);
        tick();
        tick();
        n_vec++;
        if (clk_out[0] !== 1'b1) begin
            n_err++;
            $display("FAIL arst_pre got %b want 1", clk_out[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({clk_out, clk_active, cfg_ack, cfg_err} !== 16'h0) begin
            n_err++;
            $display("FAIL arst_now got %h want 0000",
                     {clk_out, clk_active, cfg_ack, cfg_err});
        end
        #2 rst_n = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            n_vec++;
            if (clk_out[0] !== e0[k] || clk_out[1] !== e1[k]) begin
                n_err++;
                $display("FAIL arst_run edge%0d got %b%b want %b%b",
                         k + 2, clk_out[1], clk_out[0], e1[k], e0[k]);
            end
        end
        n_vec++;
        if (cfg_err !== 4'h0) begin
            n_err++;
            $display("FAIL arst_err got %b want 0000", cfg_err);
        end
    endtask

`ifdef CRCU_CLK_DIRECT_DIV_EN
    task automatic test_direct();
        set_word(0, 32'h0);
        repeat (6) tick();
        set_word(0, 32'h0A28);
        tick();
        for (int k = 0; k < 10; k++) begin
            tick();
            n_vec++;
            if (clk_out[0] !== (k < 5)) begin
                n_err++;
                $display("FAIL direct_n10 cnt%0d got %b want %b",
                         k, clk_out[0], (k < 5));
            end
        end
        tick();
        set_word(0, 32'h0128);
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_vec++;
            if (clk_out[0] !== ((k % 10) < 5) || cfg_ack[0] !== 1'b0) begin
                n_err++;
                $display("FAIL direct_div1 edge%0d got out=%b ack=%b want %b 0",
                         k, clk_out[0], cfg_ack[0], ((k % 10) < 5));
            end
        end
        n_vec++;
        if (cfg_err[0] !== 1'b1) begin
            n_err++;
            $display("FAIL direct_err got %b want 1", cfg_err[0]);
        end
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        ctl   = '0;
        test_reset();
        test_start_ch0();
        test_div_change();
        test_gate();
        test_reserved();
        test_async_reset();
`ifdef CRCU_CLK_DIRECT_DIV_EN
        test_direct();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
